// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC sampling path.
package adc_pkg;

    localparam int ADC_W = 10;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        IDLE      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Offset-binary to two's complement: flipping the MSB recentres mid-scale at zero.
    function automatic logic [ADC_W-1:0] offset_to_signed(input logic [ADC_W-1:0] code);
        return {~code[ADC_W-1], code[ADC_W-2:0]};
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Free-running sample-rate divider: one-cycle tick every CLK_DIV cycles while enabled.
module rate_divider #(
    parameter int CLK_DIV = 1250
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;

    assign tick = enable && (count_reg == '0);

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            count_reg <= RELOAD;
        end else if (!enable || tick) begin
            count_reg <= RELOAD;
        end else begin
            count_reg <= count_reg - ONE;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// Paces spi2adc conversions, converts results to two's complement and buffers
// them in a one-entry valid/ready register with sticky fault flags.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 1250,
    parameter int TIMEOUT = 2000,
    parameter int DATA_W  = 10
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clr_err,
    output logic              adc_start,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_data_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic [DATA_W-1:0] sample_raw,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              timeout_err,
    output logic              rate_err,
    output logic              overrun_err
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic              tick;
    state_t            state_reg, state_next;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              start_now;
    logic              capture;
    logic              timeout_hit;
    logic              adc_start_reg;
    logic [DATA_W-1:0] sample_out_reg, sample_raw_reg;
    logic              sample_valid_reg;
    logic              timeout_err_reg, rate_err_reg, overrun_err_reg;
    logic [DATA_W-1:0] signed_code;
    logic              transfer;
    logic              rate_set, overrun_set;

    rate_divider #(.CLK_DIV(CLK_DIV)) u_rate_divider (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    generate
        if (DATA_W == ADC_W) begin : g_pkg_map
            assign signed_code = offset_to_signed(adc_data);
        end else begin : g_generic_map
            assign signed_code = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        start_now   = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            SYNC: begin
                if (adc_data_valid) state_next = IDLE;
            end
            IDLE: begin
                if (tick) begin
                    start_now  = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (to_cnt_reg == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = SYNC;
                end else if (!adc_data_valid) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (to_cnt_reg == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = SYNC;
                end else if (adc_data_valid) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    assign transfer    = sample_valid_reg && sample_ready;
    assign rate_set    = tick && (state_reg != IDLE);
    assign overrun_set = capture && sample_valid_reg && !sample_ready;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_reg  <= SYNC;
            to_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_now) begin
                to_cnt_reg <= '0;
            end else if ((state_reg == WAIT_BUSY || state_reg == WAIT_DONE) && !timeout_hit) begin
                to_cnt_reg <= to_cnt_reg + TO_ONE;
            end
        end
    end

    // Capture takes priority over transfer so a coincident sample is never lost.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            adc_start_reg    <= 1'b0;
            sample_out_reg   <= '0;
            sample_raw_reg   <= '0;
            sample_valid_reg <= 1'b0;
            timeout_err_reg  <= 1'b0;
            rate_err_reg     <= 1'b0;
            overrun_err_reg  <= 1'b0;
        end else begin
            adc_start_reg <= start_now;
            if (capture) begin
                sample_out_reg   <= signed_code;
                sample_raw_reg   <= adc_data;
                sample_valid_reg <= 1'b1;
            end else if (transfer) begin
                sample_valid_reg <= 1'b0;
            end
            timeout_err_reg <= timeout_hit || (timeout_err_reg && !clr_err);
            rate_err_reg    <= rate_set    || (rate_err_reg    && !clr_err);
            overrun_err_reg <= overrun_set || (overrun_err_reg && !clr_err);
        end
    end

    assign adc_start    = adc_start_reg;
    assign sample_out   = sample_out_reg;
    assign sample_raw   = sample_raw_reg;
    assign sample_valid = sample_valid_reg;
    assign timeout_err  = timeout_err_reg;
    assign rate_err     = rate_err_reg;
    assign overrun_err  = overrun_err_reg;

endmodule

// File: doc/adc_sampler.md
Name: adc_sampler

Overview:
- Sample-rate controller that sits around spi2adc: it drives spi2adc's start input upstream and consumes its 10-bit result and data_valid downstream.
- Issues conversions at a fixed rate derived from a parameterised divider of the 50 MHz sysclk.
- Converts each offset-binary result to two's complement and presents it on a one-entry valid/ready output register for the audio effect chain.
- Flags timeouts, missed rate ticks and output overruns.

Parameters:
- CLK_DIV, 1250, sysclk cycles per sample period (1250 gives 40 kHz); must be at least 1000.
- TIMEOUT, 2000, maximum sysclk cycles allowed from the start pulse to conversion done.
- DATA_W, 10, ADC result width.

Ports:
- sysclk  in  1  50 MHz system clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  allows new conversions while high.
- clr_err  in  1  clears all sticky error flags.
- adc_start  out  1  one-cycle start pulse to spi2adc.
- adc_data  in  DATA_W  data_from_adc from spi2adc.
- adc_data_valid  in  1  data_valid from spi2adc; high = idle/result stable, low = converting.
- sample_out  out  DATA_W  two's-complement sample.
- sample_raw  out  DATA_W  unmodified ADC code.
- sample_valid  out  1  output register holds an unconsumed sample.
- sample_ready  in  1  consumer accepts the sample when high together with sample_valid.
- timeout_err  out  1  sticky flag.
- rate_err  out  1  sticky flag.
- overrun_err  out  1  sticky flag.

Behaviour:
- Reset (rst_n=0 at a sysclk edge):
  - FSM goes to SYNC; divider loads CLK_DIV-1.
  - adc_start=0, sample_out=0, sample_raw=0, sample_valid=0, all error flags=0.
- Divider:
  - While enable=1: decrements, and on reaching 0 produces a one-cycle rate tick and reloads CLK_DIV-1.
  - While enable=0: held at CLK_DIV-1.
- FSM states:
  - SYNC: wait for adc_data_valid=1 for one cycle, then go to IDLE. spi2adc has no reset and may still be mid-conversion, so this prevents capturing a stale result.
  - IDLE: on a rate tick, assert adc_start for exactly one cycle, clear the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when adc_data_valid=0.
  - WAIT_DONE: when adc_data_valid=1, go to IDLE and perform the capture in the same edge (see Capture).
- Timeout:
  - The counter increments in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT-1: set timeout_err, go to SYNC, no capture.
- Rate tick while FSM is not in IDLE: set rate_err; the tick is dropped, not queued.
- enable falling mid-conversion: the current conversion completes and is captured; no new starts are issued.
- Capture:
  - Same edge as the WAIT_DONE exit: sample_raw <= adc_data, sample_out <= {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]}.
  - sample_valid is 1 on the next cycle, giving 1-cycle latency from the adc_data_valid rising edge.
  - Mapping examples: code 0x200 -> 0, 0x3FF -> +511, 0x000 -> -512.
- Output handshake:
  - Transfer occurs when sample_valid && sample_ready; sample_valid clears next cycle unless a capture occurs on the same edge.
  - Capture while sample_valid=1 and sample_ready=0: overwrite the register, set overrun_err, sample_valid stays 1.
  - Capture and transfer on the same edge: load the new sample, sample_valid stays 1, no overrun.
- Error flags:
  - Sticky until clr_err=1 or reset.
  - If clr_err and a set condition occur on the same edge, set wins.
- Reset mid-conversion: abandon immediately, go to SYNC; no adc_start until spi2adc returns to idle.

Decomposition:
- Package adc_pkg: FSM state enum (SYNC, IDLE, WAIT_BUSY, WAIT_DONE), ADC_W=10, offset_to_signed function.
- Sub-module rate_divider (parameter CLK_DIV; ports sysclk, rst_n, enable, tick) is natural and reusable for the DAC path.
- Capture, handshake and error logic stay in the top module.

Test Plan:
- Behavioural spi2adc model (data_valid low for 850 cycles after start), adc_data=0x3FF, enable=1, sample_ready=1 → adc_start pulses every 1250 cycles; sample_out=+511 (0x1FF) and sample_raw=0x3FF valid 1 cycle after each data_valid rise; no errors.
- adc_data=0x200 then 0x000 → sample_out=0 then -512 (0x200).
- sample_ready=0 for 3 sample periods → sample_valid stays 1, last sample held, overrun_err=1. Pulse clr_err → flag clears. Capture coincident with ready → no overrun.
- ADC model never drops data_valid → timeout_err set 2000 cycles after adc_start, FSM in SYNC; next start issued on the next tick.
- CLK_DIV=500 with 850-cycle conversions → rate_err=1 and starts occur every 1000 cycles (every other tick).
- Assert rst_n=0 for 1 cycle 400 cycles into a conversion → no adc_start until the model's data_valid returns high; all outputs 0 immediately after reset; the first post-reset sample is correct.
